// File: rtl/fft8_ctrl_if.sv
// Control/address bundle between the 8-point FFT sequencer and its datapath and memory.
// FFT8_CTRL_IFFT_EN adds the inv request input.
interface fft8_ctrl_if;
    logic       start;
`ifdef FFT8_CTRL_IFFT_EN
    logic       inv;
`endif
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [2:0] w;
    logic [1:0] stage;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [2:0] wr_addr_b;

    modport master (
        input  start,
`ifdef FFT8_CTRL_IFFT_EN
        input  inv,
`endif
        output busy, done, rd_en, rd_addr_a, rd_addr_b, w, stage,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
`ifdef FFT8_CTRL_IFFT_EN
        output inv,
`endif
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, w, stage,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft8_ctrl.sv
// Sequencer for an 8-point radix-2 DIT FFT: 3 stages x 4 butterflies, delayed write-back.
// Optional macro FFT8_CTRL_IFFT_EN selects conjugate twiddles when inv is set at start.
module fft8_ctrl #(
    parameter int BF_LAT = 2  // butterfly latency, 1..4
) (
    input  logic        clk,
    input  logic        reset,
    fft8_ctrl_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic       en;
        logic [2:0] addr_a;
        logic [2:0] addr_b;
    } wb_t;

    state_t     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [1:0] k_q, k_d;
    logic [1:0] wcnt_q, wcnt_d;
`ifdef FFT8_CTRL_IFFT_EN
    logic       inv_q, inv_d;
`endif

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rd_en_q, rd_en_d;
    logic [2:0] rd_addr_a_q, rd_addr_a_d;
    logic [2:0] rd_addr_b_q, rd_addr_b_d;
    logic [2:0] w_q, w_d;
    logic [1:0] stage_q, stage_d;
    wb_t        wb_pipe_q [BF_LAT];
    wb_t        wb_pipe_d [BF_LAT];

    logic [2:0] span, grp, pos, w_fwd;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
`ifdef FFT8_CTRL_IFFT_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    s_d     = 2'd0;
                    k_d     = 2'd0;
`ifdef FFT8_CTRL_IFFT_EN
                    inv_d   = bus.inv;
`endif
                end
            end
            S_ISSUE: begin
                if (k_q == 2'd3) begin
                    state_d = S_WAIT;
                    wcnt_d  = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_WAIT: begin
                // Drain so the last write of this stage lands before the next stage reads.
                if (wcnt_q == 2'(BF_LAT - 1)) begin
                    if (s_q < 2'd2) begin
                        state_d = S_ISSUE;
                        s_d     = s_q + 2'd1;
                        k_d     = 2'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the next state.
    always_comb begin
        span        = 3'd1 << s_d;
        grp         = {1'b0, k_d} >> s_d;
        pos         = {1'b0, k_d} & (span - 3'd1);
        w_fwd       = pos << (2'd2 - s_d);
        rd_en_d     = 1'b0;
        rd_addr_a_d = 3'd0;
        rd_addr_b_d = 3'd0;
        w_d         = 3'd0;
        stage_d     = 2'd0;
        busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
        done_d      = (state_d == S_DONE);
        if (state_d == S_ISSUE) begin
            rd_en_d     = 1'b1;
            rd_addr_a_d = (grp << (s_d + 2'd1)) | pos;
            rd_addr_b_d = ((grp << (s_d + 2'd1)) | pos) + span;
            stage_d     = s_d;
`ifdef FFT8_CTRL_IFFT_EN
            w_d         = inv_d ? (3'd0 - w_fwd) : w_fwd;
`else
            w_d         = w_fwd;
`endif
        end
    end

    always_comb begin
        wb_pipe_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
        for (int i = 1; i < BF_LAT; i++) begin
            wb_pipe_d[i] = wb_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            s_q         <= 2'd0;
            k_q         <= 2'd0;
            wcnt_q      <= 2'd0;
`ifdef FFT8_CTRL_IFFT_EN
            inv_q       <= 1'b0;
`endif
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= 3'd0;
            rd_addr_b_q <= 3'd0;
            w_q         <= 3'd0;
            stage_q     <= 2'd0;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
`ifdef FFT8_CTRL_IFFT_EN
            inv_q       <= inv_d;
`endif
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            w_q         <= w_d;
            stage_q     <= stage_d;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_pipe_q[i] <= wb_pipe_d[i];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.w         = w_q;
    assign bus.stage     = stage_q;
    assign bus.wr_en     = wb_pipe_q[BF_LAT-1].en;
    assign bus.wr_addr_a = wb_pipe_q[BF_LAT-1].addr_a;
    assign bus.wr_addr_b = wb_pipe_q[BF_LAT-1].addr_b;

endmodule

// File: tb/tb_fft8_ctrl.sv
// Scoreboard bench for fft8_ctrl: a stage/pair-enumeration model predicts per-cycle events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fft8_ctrl;

    localparam int L = 2;
`ifdef FFT8_CTRL_IFFT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] w;
        logic [1:0] s;
    } ev_t;

    typedef struct {
        int s;
        int e;
    } win_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   idle_from = 0;
    bit   chk_en = 1'b0;

    ev_t  rdq[$];
    ev_t  wrq[$];
    int   doneq[$];
    win_t bwq[$];

    fft8_ctrl_if bus();

    fft8_ctrl #(.BF_LAT(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Stage s pairs every index a whose bit s is clear with a+span, in ascending order;
    // the twiddle exponent is the position within the group scaled to an 8-point circle.
    task automatic accept(input int c0, input logic iv);
        ev_t e;
        win_t wn;
        int n;
        int span;
        for (int s = 0; s < 3; s++) begin
            span = 1 << s;
            n = 0;
            for (int a = 0; a < 8; a++) begin
                if ((a & span) == 0) begin
                    e.cyc = c0 + 1 + s * (4 + L) + n;
                    e.a   = 3'(a);
                    e.b   = 3'(a + span);
                    e.w   = 3'(((a % span) * 8) / (2 * span));
                    if (iv && INV_EN) e.w = 3'((8 - int'(e.w)) % 8);
                    e.s   = 2'(s);
                    rdq.push_back(e);
                    e.cyc = e.cyc + L;
                    wrq.push_back(e);
                    n++;
                end
            end
        end
        doneq.push_back(c0 + 13 + 3 * L);
        wn.s = c0 + 1;
        wn.e = c0 + 12 + 3 * L;
        bwq.push_back(wn);
        idle_from = c0 + 14 + 3 * L;
    endtask

    task automatic purge(input int c);
        while (rdq.size() > 0 && rdq[rdq.size()-1].cyc > c) void'(rdq.pop_back());
        while (wrq.size() > 0 && wrq[wrq.size()-1].cyc > c) void'(wrq.pop_back());
        while (doneq.size() > 0 && doneq[doneq.size()-1] > c) void'(doneq.pop_back());
        while (bwq.size() > 0 && bwq[bwq.size()-1].s > c) void'(bwq.pop_back());
        if (bwq.size() > 0 && bwq[bwq.size()-1].e > c) bwq[bwq.size()-1].e = c;
        idle_from = c + 1;
    endtask

    task automatic drive(input logic st, input logic rs, input logic iv);
        bus.start = st;
        reset     = rs;
`ifdef FFT8_CTRL_IFFT_EN
        bus.inv   = iv;
`endif
        if (rs) purge(cyc);
        else if (st && cyc >= idle_from) accept(cyc, iv);
        @(posedge clk);
        #1;
    endtask

    ev_t  m_e;
    logic m_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
                m_e = rdq.pop_front();
                check("rd", {20'd0, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.w, bus.stage},
                      {20'd0, 1'b1, m_e.a, m_e.b, m_e.w, m_e.s});
            end else begin
                check("rd_idle", {20'd0, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.w, bus.stage}, 32'd0);
            end
            if (wrq.size() > 0 && wrq[0].cyc == cyc) begin
                m_e = wrq.pop_front();
                check("wr", {25'd0, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b}, {25'd0, 1'b1, m_e.a, m_e.b});
            end else begin
                check("wr_idle", {25'd0, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b}, 32'd0);
            end
            m_exp = (doneq.size() > 0 && doneq[0] == cyc);
            if (m_exp) void'(doneq.pop_front());
            check("done", {31'd0, bus.done}, {31'd0, m_exp});
            while (bwq.size() > 0 && bwq[0].e < cyc) void'(bwq.pop_front());
            m_exp = (bwq.size() > 0 && bwq[0].s <= cyc);
            check("busy", {31'd0, bus.busy}, {31'd0, m_exp});
        end
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
`ifdef FFT8_CTRL_IFFT_EN
        bus.inv   = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b0);

        // Single nominal run with inv set at start and toggling afterwards.
        drive(1'b1, 1'b0, 1'b1);
        repeat (30) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // start held high across two full runs.
        repeat (2 * (14 + 3 * L) + 5) drive(1'b1, 1'b0, 1'b0);
        repeat (25) drive(1'b0, 1'b0, 1'b0);

        // Reset at cycle 8 of a run, then a fresh run.
        drive(1'b1, 1'b0, 1'b0);
        repeat (7) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (30) drive(1'b0, 1'b0, 1'b0);

        // Random starts, inv and occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic rs;
            rs = 1'($urandom_range(0, 79) == 0);
            drive(1'($urandom_range(0, 3) == 0) && !rs, rs, 1'($urandom_range(0, 1)));
        end
        repeat (30) drive(1'b0, 1'b0, 1'b0);

        check("rdq_left", rdq.size(), 0);
        check("wrq_left", wrq.size(), 0);
        check("doneq_left", doneq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
